// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit
// ----------------------------------------------------------------------------
// Multi-cycle multiply/divide unit for the MIPS datapath. It implements
// MULT, MULTU, DIV and DIVU into the HI/LO result registers and accepts
// MTHI/MTLO writes while idle. The EX stage drives it through a
// start/busy/done handshake and stalls MFHI/MFLO while busy is high.
//
// Multiplication is shift-add, one multiplier bit per cycle. Division is
// restoring, one quotient bit per cycle. Signed operations work on operand
// magnitudes and apply sign correction in the final state.
//
// Parameters:
//   WIDTH        operand width and width of each of HI and LO (>= 4)
//   CNT_W        iteration counter width, derived from WIDTH
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        begin an operation (sampled only while idle)
//   op           0=MULT, 1=MULTU, 2=DIV, 3=DIVU
//   operand_a    multiplicand / dividend (rs), also the MTHI/MTLO data
//   operand_b    multiplier / divisor (rt)
//   mthi, mtlo   write operand_a into HI / LO (idle and start low only)
//   busy         operation in progress
//   done         one-cycle pulse when an operation updates HI/LO
//   div_by_zero  valid with done; set for DIV/DIVU with operand_b == 0
//   hi, lo       result registers
//
// Build option:
//   MDU_FAST_MULT_EN  when defined, MULT/MULTU use a native single-cycle
//                     product and skip the iterative RUN state. Division
//                     is iterative either way.
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Result registers and status
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    // Working state latched at start
    logic [CNT_W-1:0]   r_cnt;
    logic               r_isDiv;
    logic               r_negQ;
    logic               r_negR;
    logic               r_divZero;
    logic [WIDTH-1:0]   r_opM;
    logic [WIDTH-1:0]   r_pHi;
    logic [WIDTH-1:0]   r_pLo;

    // Operand conditioning
    logic               w_isSigned;
    logic               w_aNeg;
    logic               w_bNeg;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic               w_fastStart;

    // Iteration datapath
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [WIDTH:0]     w_divShift;
    logic               w_divGe;
    logic [WIDTH-1:0]   w_divDiff;
    logic [WIDTH-1:0]   w_divHi;
    logic [WIDTH-1:0]   w_divLo;

    // Final sign correction
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Signed ops (op[0] == 0) run on magnitudes. The magnitude of the most
    // negative value wraps to itself, which read as unsigned is the right
    // magnitude, so no special case is needed for it.
    assign w_isSigned = ~op[0];
    assign w_aNeg     = w_isSigned & operand_a[WIDTH-1];
    assign w_bNeg     = w_isSigned & operand_b[WIDTH-1];
    assign w_absA     = w_aNeg ? ('0 - operand_a) : operand_a;
    assign w_absB     = w_bNeg ? ('0 - operand_b) : operand_b;

`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] w_fastProd;

    // Native product of the magnitudes, loaded straight into the product
    // registers so the FIN state corrects its sign like the iterative path.
    assign w_fastProd  = {{WIDTH{1'b0}}, w_absA} * {{WIDTH{1'b0}}, w_absB};
    assign w_fastStart = ~op[1];
`else
    assign w_fastStart = 1'b0;
`endif

    // Shift-add step: the multiplier sits in r_pLo and is consumed from
    // bit 0 while the partial product grows in from the top.
    assign w_mulSum  = {1'b0, r_pHi} + (r_pLo[0] ? {1'b0, r_opM} : {(WIDTH+1){1'b0}});
    assign w_mulNext = {w_mulSum, r_pLo[WIDTH-1:1]};

    // Restoring step: r_pHi is the partial remainder, r_pLo shifts the
    // dividend out of the top and the quotient bits in at the bottom. The
    // remainder stays below the divisor, so the difference fits WIDTH bits.
    assign w_divShift = {r_pHi, r_pLo[WIDTH-1]};
    assign w_divGe    = (w_divShift >= {1'b0, r_opM});
    assign w_divDiff  = w_divShift[WIDTH-1:0] - r_opM;
    assign w_divHi    = w_divGe ? w_divDiff : w_divShift[WIDTH-1:0];
    assign w_divLo    = {r_pLo[WIDTH-2:0], w_divGe};

    // A divide by zero naturally ends with the dividend magnitude in the
    // remainder, so after the remainder sign fix HI already equals operand_a.
    assign w_prod    = {r_pHi, r_pLo};
    assign w_prodFix = r_negQ ? ('0 - w_prod) : w_prod;
    assign w_quot    = r_negQ ? ('0 - r_pLo) : r_pLo;
    assign w_rem     = r_negR ? ('0 - r_pHi) : r_pHi;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: RUN lasts exactly WIDTH cycles; the fast multiply
    // option jumps from IDLE straight to FIN.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = w_fastStart ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_nextState = S_FIN;
                end
            end
            S_FIN: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Datapath: latch operands at start, iterate in RUN, commit in FIN.
    // HI/LO are only touched by FIN or by MTHI/MTLO while idle, so their
    // old values stay readable for the whole operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_cnt     <= '0;
            r_isDiv   <= 1'b0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_divZero <= 1'b0;
            r_opM     <= '0;
            r_pHi     <= '0;
            r_pLo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dbz     <= 1'b0;
                        r_cnt     <= CNT_INIT;
                        r_isDiv   <= op[1];
                        r_negQ    <= w_aNeg ^ w_bNeg;
                        r_negR    <= w_aNeg;
                        r_divZero <= op[1] & (operand_b == '0);
                        r_opM     <= op[1] ? w_absB : w_absA;
                        r_pHi     <= '0;
                        r_pLo     <= op[1] ? w_absA : w_absB;
`ifdef MDU_FAST_MULT_EN
                        if (!op[1]) begin
                            {r_pHi, r_pLo} <= w_fastProd;
                        end
`endif
                    end else begin
                        if (mthi) begin
                            r_hi <= operand_a;
                        end
                        if (mtlo) begin
                            r_lo <= operand_a;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_isDiv) begin
                        r_pHi <= w_divHi;
                        r_pLo <= w_divLo;
                    end else begin
                        {r_pHi, r_pLo} <= w_mulNext;
                    end
                end
                S_FIN: begin
                    r_done <= 1'b1;
                    r_dbz  <= r_divZero;
                    if (r_isDiv) begin
                        r_hi <= w_rem;
                        r_lo <= r_divZero ? {WIDTH{1'b1}} : w_quot;
                    end else begin
                        {r_hi, r_lo} <= w_prodFix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// tb_mult_div_unit
// ----------------------------------------------------------------------------
// Scoreboard bench for mult_div_unit (WIDTH = 32). Every accepted start
// pushes the expected HI/LO/div_by_zero and the required latency into a
// queue; a monitor pops and compares whenever done is seen. Expected
// results come from plain 64-bit arithmetic on the operands.
// ============================================================================
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  operand_a;
    logic [WIDTH-1:0]  operand_b;
    logic              mthi;
    logic              mtlo;
    logic              busy;
    logic              done;
    logic              div_by_zero;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int unsigned startCyc;
        int unsigned lat;
    } exp_t;

    exp_t        sbQ[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    // Free-running clock and a cycle counter used to measure latency
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc++;
    end

    // One comparison: counts it and reports a mismatch
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: results straight from the architectural definition
    function automatic exp_t refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t            e;
        longint          sa;
        longint          sb;
        longint          sp;
        longint          sq;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        e.dbz = 1'b0;
        e.startCyc = 0;
        e.hi = '0;
        e.lo = '0;
        case (o)
            2'd0: begin
                sp = sa * sb;
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            2'd1: begin
                up = ua * ub;
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                end else if (o == 2'd2) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    e.lo = sq[31:0];
                    e.hi = sr[31:0];
                end else begin
                    up = ua / ub;
                    e.lo = up[31:0];
                    up = ua % ub;
                    e.hi = up[31:0];
                end
            end
        endcase
`ifdef MDU_FAST_MULT_EN
        e.lat = (o[1] == 1'b0) ? 1 : WIDTH + 1;
`else
        e.lat = WIDTH + 1;
`endif
        return e;
    endfunction

    // Issue one operation from the current (non-edge) time; returns 1 time
    // unit after the accepting edge and queues the expected response.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        e = refModel(o, a, b);
        e.startCyc = cyc;
        sbQ.push_back(e);
        start = 1'b0;
    endtask

    // Wait on falling edges until busy drops, bounded
    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idleTimeout", {63'd0, busy}, 64'd0);
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedDone", 64'd1, 64'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("hi", {32'd0, hi}, {32'd0, e.hi});
                checkOutput("lo", {32'd0, lo}, {32'd0, e.lo});
                checkOutput("divByZero", {63'd0, div_by_zero}, {63'd0, e.dbz});
                checkOutput("busyAtDone", {63'd0, busy}, 64'd0);
                checkOutput("latency", 64'(cyc - e.startCyc), 64'(e.lat));
            end
        end
    end

    // Safety net against a hung design
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test plan followed by randomized operations
    initial begin
        logic [1:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        logic [31:0] specials [5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;

        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'd0;
        operand_a = '0;
        operand_b = '0;
        mthi      = 1'b0;
        mtlo      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetHi", {32'd0, hi}, 64'd0);
        checkOutput("resetLo", {32'd0, lo}, 64'd0);
        checkOutput("resetBusy", {63'd0, busy}, 64'd0);
        checkOutput("resetDone", {63'd0, done}, 64'd0);
        checkOutput("resetDbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Signed and unsigned multiply
        applyStimulus(2'd0, 32'd10, 32'hFFFF_FFEC);
        checkOutput("busyAfterStart", {63'd0, busy}, 64'd1);
        waitIdle();
        applyStimulus(2'd1, 32'hFFFF_FFFF, 32'd2);
        waitIdle();

        // Signed and unsigned divide
        applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2);
        waitIdle();
        applyStimulus(2'd3, 32'd20, 32'd3);
        waitIdle();

        // Divide by zero, then overflow case; flag clears on the next start
        applyStimulus(2'd3, 32'd20, 32'd0);
        waitIdle();
        applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("dbzClearOnStart", {63'd0, div_by_zero}, 64'd0);
        waitIdle();

        // Start and MTHI while busy are ignored
        applyStimulus(2'd0, 32'd7, 32'hFFFF_FFFD);
        repeat (4) @(negedge clk);
        start     = 1'b1;
        op        = 2'd3;
        operand_a = 32'd99;
        operand_b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        mthi      = 1'b1;
        operand_a = 32'h1234;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        waitIdle();

        // MTLO alone, then MTHI and MTLO together, while idle
        @(negedge clk);
        mtlo      = 1'b1;
        operand_a = 32'h55;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        checkOutput("mtloLo", {32'd0, lo}, 64'h55);
        checkOutput("mtloHiKept", {32'd0, hi}, 64'hFFFF_FFFF);
        checkOutput("mtloNoDone", {63'd0, done}, 64'd0);
        @(negedge clk);
        mthi      = 1'b1;
        mtlo      = 1'b1;
        operand_a = 32'hA5A5_0F0F;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        checkOutput("mthiBothHi", {32'd0, hi}, 64'hA5A5_0F0F);
        checkOutput("mtloBothLo", {32'd0, lo}, 64'hA5A5_0F0F);
        checkOutput("mtBothNoDone", {63'd0, done}, 64'd0);
        @(negedge clk);

        // Reset in the middle of a divide aborts it
        applyStimulus(2'd2, 32'd1000, 32'd7);
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abortHi", {32'd0, hi}, 64'd0);
        checkOutput("abortLo", {32'd0, lo}, 64'd0);
        checkOutput("abortBusy", {63'd0, busy}, 64'd0);
        checkOutput("abortDone", {63'd0, done}, 64'd0);
        sbQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back: the second start lands in the done cycle
        applyStimulus(2'd3, 32'd100, 32'd9);
        waitIdle();
        checkOutput("doneInB2bCycle", {63'd0, done}, 64'd1);
        applyStimulus(2'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFA);
        waitIdle();

        // Randomized operations, mixing in boundary operand values
        for (int i = 0; i < 40; i++) begin
            rOp = 2'($urandom_range(3, 0));
            rA  = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(4, 0)] : $urandom;
            rB  = ($urandom_range(7, 0) == 0) ? 32'd0 :
                  (($urandom_range(3, 0) == 0) ? specials[$urandom_range(4, 1)] : $urandom);
            if ($urandom_range(2, 0) == 0) begin
                rB = rB >> $urandom_range(28, 0);
            end
            applyStimulus(rOp, rA, rB);
            waitIdle();
        end

        repeat (3) @(negedge clk);
        checkOutput("queueEmpty", 64'(sbQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
